// File: rtl/version_info_pkg.sv
// Shared types and constants for the version/USR_ACCESS capture and read arbiter.
package version_info_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_QUAL = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_VER_LO = 2'd0;
    localparam logic [1:0] ADDR_VER_HI = 2'd1;
    localparam logic [1:0] ADDR_USR    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int ST_READY_BIT = 31;
    localparam int ST_RETRY_LSB = 8;
    localparam int ST_STATE_LSB = 0;

    function automatic logic [31:0] pack_status(input logic rdy, input logic [7:0] retry,
                                                input state_t st);
        logic [31:0] s;
        s = '0;
        s[ST_READY_BIT]                  = rdy;
        s[ST_RETRY_LSB +: 8]             = retry;
        s[ST_STATE_LSB +: 2]             = st;
        return s;
    endfunction

endpackage

// File: rtl/version_info_arbiter_rr.sv
// Combinational round-robin pick: first eligible requester at or after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] next_ptr,
    output logic          any
);
    always_comb begin
        int idx;
        winner   = '0;
        next_ptr = ptr;
        any      = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!any && eligible[idx]) begin
                any         = 1'b1;
                winner[idx] = 1'b1;
                next_ptr    = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end
endmodule

// File: rtl/version_info_arbiter.sv
// Qualifies/latches build version and USR_ACCESS word, then serves them to
// NUM_REQ requesters through a registered round-robin read port.
module version_info_arbiter
    import version_info_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            value_i,
    input  logic                   usr_datavalid_i,
    input  logic [31:0]            usr_data_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [2*NUM_REQ-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic [31:0]            rsp_data_o,
    output logic                   ready_o
);
    localparam int PW = $clog2(NUM_REQ);

    logic        dv_meta, dv_s;
    state_t      state;
    logic [31:0] ref_word, usr_word;
    logic [63:0] ver;
    logic [3:0]  cnt;
    logic [7:0]  retry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_meta <= 1'b0;
            dv_s    <= 1'b0;
        end else begin
            dv_meta <= usr_datavalid_i;
            dv_s    <= dv_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_SYNC;
            ref_word <= '0;
            usr_word <= '0;
            ver      <= '0;
            cnt      <= '0;
            retry    <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_SYNC: if (dv_s) begin
                    state    <= S_QUAL;
                    ref_word <= usr_data_i;
                    cnt      <= 4'd1;
                end
                S_QUAL: begin
                    if (!dv_s) begin
                        state <= S_SYNC;
                    end else if (usr_data_i == ref_word) begin
                        cnt <= cnt + 4'd1;
                        if (cnt + 4'd1 == 4'(STABLE_CNT)) begin
                            state    <= S_LOCK;
                            usr_word <= ref_word;
                            ver      <= value_i;
                            ready_o  <= 1'b1;
                        end
                    end else begin
                        ref_word <= usr_data_i;
                        cnt      <= 4'd1;
                        if (retry != 8'hFF) retry <= retry + 8'd1;
                    end
                end
                default: ready_o <= 1'b1;  // locked until reset
            endcase
        end
    end

    // Masking by the current grant stops a held request from winning twice in a row.
    logic [NUM_REQ-1:0] eligible, winner;
    logic [PW-1:0]      ptr, next_ptr;
    logic               any;
    logic [1:0]         win_addr, addr_q;

    assign eligible = ready_o ? (req_i & ~gnt_o) : '0;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .next_ptr (next_ptr),
        .any      (any)
    );

    always_comb begin
        win_addr = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (winner[k]) win_addr = req_addr_i[2*k +: 2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_o       <= '0;
            ptr         <= '0;
            addr_q      <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
        end else begin
            gnt_o       <= winner;
            if (any) begin
                ptr    <= next_ptr;
                addr_q <= win_addr;
            end
            rsp_valid_o <= gnt_o;
            if (|gnt_o) begin
                case (addr_q)
                    ADDR_VER_LO: rsp_data_o <= ver[31:0];
                    ADDR_VER_HI: rsp_data_o <= ver[63:32];
                    ADDR_USR:    rsp_data_o <= usr_word;
                    default:     rsp_data_o <= pack_status(ready_o, retry, state);
                endcase
            end
        end
    end
endmodule

// File: tb/tb_version_info_arbiter.sv
// Scenario bench for version_info_arbiter with a response scoreboard.
module tb_version_info_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int STABLE_CNT = 4;
    localparam logic [63:0] VER = 64'h0123_4567_89AB_CDEF;

    logic        clk, rst;
    logic [63:0] value;
    logic        dv;
    logic [31:0] usr_data;
    logic [3:0]  req;
    logic [7:0]  req_addr;
    logic [3:0]  gnt, rsp_valid;
    logic [31:0] rsp_data;
    logic        ready;

    version_info_arbiter #(.NUM_REQ(NUM_REQ), .STABLE_CNT(STABLE_CNT)) dut (
        .clk             (clk),
        .rst             (rst),
        .value_i         (value),
        .usr_datavalid_i (dv),
        .usr_data_i      (usr_data),
        .req_i           (req),
        .req_addr_i      (req_addr),
        .gnt_o           (gnt),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .ready_o         (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int idx; logic [31:0] data; } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_gnt[$];
    rsp_t        exp_rsp[$];
    logic [31:0] usr_exp;
    logic [7:0]  retry_exp;

    function automatic logic [31:0] addr_data(input int a);
        case (a)
            0:       return VER[31:0];
            1:       return VER[63:32];
            2:       return usr_exp;
            default: return {1'b1, 15'b0, retry_exp, 6'b0, 2'd2};
        endcase
    endfunction

    task automatic expect_read(input int idx, input int a);
        rsp_t e;
        e.idx  = idx;
        e.data = addr_data(a);
        exp_gnt.push_back(idx);
        exp_rsp.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; dv = 1'b0; req = '0;
        exp_gnt.delete();
        exp_rsp.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (!ready && gnt !== 4'b0) begin
                errors++;
                $display("FAIL gnt_before_lock: gnt=%b while ready=0, required 0000", gnt);
            end
            if (ready) break;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_timeout: ready=%b after %0d cycles, required 1", ready, n);
        end
    endtask

    task automatic run_traffic(input bit oneshot, input int budget, output int first_gnt);
        logic [3:0] prev_gnt;
        int   cyc, g;
        rsp_t e;
        prev_gnt = gnt; cyc = 0; first_gnt = -1;
        while (exp_rsp.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid !== 4'b0) begin
                checks++;
                e = exp_rsp.pop_front();
                if (rsp_valid !== prev_gnt || rsp_valid !== 4'(1 << e.idx) || rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL rsp: valid=%b data=%h prev_gnt=%b, required valid=%b data=%h",
                             rsp_valid, rsp_data, prev_gnt, 4'(1 << e.idx), e.data);
                end
            end
            if (gnt !== 4'b0 && exp_gnt.size() > 0) begin
                checks++;
                if (first_gnt < 0) first_gnt = cyc;
                g = exp_gnt.pop_front();
                if (gnt !== 4'(1 << g)) begin
                    errors++;
                    $display("FAIL gnt_order: gnt=%b, required %b", gnt, 4'(1 << g));
                end
            end
            if (oneshot) req = req & ~gnt;
            prev_gnt = gnt;
        end
        checks++;
        if (exp_rsp.size() != 0) begin
            errors++;
            $display("FAIL traffic_timeout: %0d responses outstanding, required 0", exp_rsp.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dv = 1'b0; usr_data = '0; req = 4'b1111; req_addr = 8'hE4;
        value = VER;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== 4'b0 || rsp_valid !== 4'b0 || rsp_data !== 32'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b rsp_valid=%b data=%h ready=%b, required all 0",
                     gnt, rsp_valid, rsp_data, ready);
        end
        req = '0;
    endtask

    task automatic test_lock();
        int n, f;
        apply_reset();
        usr_exp = 32'h5A5A_0001; retry_exp = 8'd0;
        rst = 1'b0; dv = 1'b1; usr_data = usr_exp;
        wait_ready(40, n);
        checks++;
        if (n < STABLE_CNT + 1 || n > STABLE_CNT + 3) begin
            errors++;
            $display("FAIL lock_latency: %0d cycles, required %0d..%0d", n, STABLE_CNT + 1, STABLE_CNT + 3);
        end
        for (int k = 0; k < 4; k++) expect_read(k, k);
        req_addr = 8'b11_10_01_00;
        req = 4'b1111;
        run_traffic(1'b1, 20, f);
    endtask

    task automatic test_contention();
        int f;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) expect_read(k, k);
        req_addr = 8'b11_10_01_00;
        req = 4'b1111;
        run_traffic(1'b0, 30, f);
        req = '0;
    endtask

    task automatic test_unstable();
        logic [31:0] seq [8];
        int n, f;
        seq = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2};
        apply_reset();
        usr_exp = 32'h2; retry_exp = 8'd5;
        rst = 1'b0; dv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            usr_data = seq[i];
            @(negedge clk);
        end
        usr_data = 32'h2;
        wait_ready(40, n);
        expect_read(0, 3);
        expect_read(1, 2);
        req_addr = 8'b00_00_10_11;
        req = 4'b0011;
        run_traffic(1'b1, 20, f);
    endtask

    task automatic test_dv_drop();
        int n, f;
        apply_reset();
        usr_exp = 32'hC0DE_0042; retry_exp = 8'd0;
        expect_read(0, 3);
        req_addr = 8'b00_00_00_11;
        req = 4'b0001;
        rst = 1'b0; dv = 1'b1; usr_data = usr_exp;
        repeat (2) @(negedge clk);
        dv = 1'b0;
        repeat (3) @(negedge clk);
        dv = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b0 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL dv_drop_no_lock: ready=%b gnt=%b, required 0 and 0000", ready, gnt);
        end
        wait_ready(40, n);
        run_traffic(1'b1, 20, f);
    endtask

    task automatic test_prelock();
        int n, f;
        apply_reset();
        usr_exp = 32'h1357_9BDF; retry_exp = 8'd0;
        expect_read(1, 2);
        expect_read(3, 0);
        req_addr = 8'b00_00_10_00;
        req = 4'b1010;
        rst = 1'b0; dv = 1'b1; usr_data = usr_exp;
        wait_ready(40, n);
        run_traffic(1'b1, 20, f);
        checks++;
        if (f != 1) begin
            errors++;
            $display("FAIL prelock_first_grant: cycle %0d after ready, required 1", f);
        end
    endtask

    task automatic test_reset_mid();
        int n, f;
        req_addr = 8'b00_00_00_01;
        req = 4'b0011;
        n = 0;
        while (gnt !== 4'b0010 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mid_setup: gnt=%b, required 0010", gnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0 || rsp_valid !== 4'b0 || ready !== 1'b0 || rsp_data !== 32'b0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b rsp_valid=%b ready=%b data=%h, required all 0",
                     gnt, rsp_valid, ready, rsp_data);
        end
        req = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) expect_read(k, 3 - k);
        req_addr = 8'b00_01_10_11;
        req = 4'b1111;
        rst = 1'b0;
        wait_ready(40, n);
        run_traffic(1'b1, 20, f);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_contention();
        test_unstable();
        test_dv_drop();
        test_prelock();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/version_info_arbiter.md
Name: version_info_arbiter

Overview:
Controller that qualifies and latches the 64-bit build version and the 32-bit USR_ACCESS configuration word, then shares them among NUM_REQ requesters (PS register bank, debug UART, ILA tagger, ...) through a round-robin read port. It sits directly behind the version/USR_ACCESS wrapper in the PL static region. It is the only consumer of those raw signals.

Parameters:
NUM_REQ, 4, number of read requesters (2..8)
STABLE_CNT, 4, consecutive identical USR_ACCESS samples required before lock (2..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
value_i  in  64  build version value from wrapper (static)
usr_datavalid_i  in  1  USR_ACCESS DATAVALID (asynchronous to clk)
usr_data_i  in  32  USR_ACCESS DATA (quasi-static)
req_i  in  NUM_REQ  per-requester read request, level
req_addr_i  in  2*NUM_REQ  per-requester word address, slice k = [2k+1:2k]
gnt_o  out  NUM_REQ  one-hot grant, one-cycle pulse
rsp_valid_o  out  NUM_REQ  one-hot response valid, one-cycle pulse
rsp_data_o  out  32  response data (shared bus)
ready_o  out  1  capture locked, reads are served

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM=S_SYNC; rr pointer=0; retry count=0; latched registers=0.
- usr_datavalid_i passes through a 2-FF synchronizer (dv_s). usr_data_i is sampled only while dv_s=1.
- Capture FSM:
  - S_SYNC: wait for dv_s=1 -> S_QUAL, load ref=usr_data_i, cnt=1.
  - S_QUAL: each cycle, if dv_s=0 -> S_SYNC. Else if usr_data_i==ref, cnt++; else ref=usr_data_i, cnt=1, retry++ (8-bit, saturates at 255). When cnt reaches STABLE_CNT -> S_LOCK, latch usr_word=ref and ver=value_i.
  - S_LOCK: ready_o=1; terminal until reset. dv_s changes are ignored.
- Address map:
  - 0: ver[31:0]
  - 1: ver[63:32]
  - 2: usr_word
  - 3: status = {ready_o, 15'b0, retry[7:0], 6'b0, state[1:0]}
  - State encoding: S_SYNC=0, S_QUAL=1, S_LOCK=2.
- Arbitration:
  - eligible = req_i & ~gnt_o, gated to 0 while ready_o=0. Requests before lock stay pending and are not dropped.
  - Round-robin starts search at pointer. Registered winner goes to gnt_o next cycle: a request sampled at edge N gives gnt_o at N+1.
  - Pointer = winner+1 mod NUM_REQ on each grant; unchanged if no grant.
  - At most one grant per cycle. Throughput is one read per cycle.
- Requester rules:
  - Hold req_i and req_addr_i stable until gnt_o[k].
  - Deasserting before grant withdraws the request.
  - req_i still high in the cycle after gnt_o[k] counts as a new request; masking by gnt_o prevents an immediate double grant.
- Response: address captured with the grant. rsp_valid_o[k]=1 and rsp_data_o valid exactly one cycle after gnt_o[k] (latency 2 from request). rsp_data_o holds its last value when no response is issued.
- A status read returns live state/retry values even though it is only granted after lock.
- Reset mid-transaction: pending grants and responses are discarded, and the capture FSM restarts at S_SYNC.

Decomposition:
- Package version_info_pkg:
  - state enum (S_SYNC/S_QUAL/S_LOCK)
  - address constants ADDR_VER_LO=0, ADDR_VER_HI=1, ADDR_USR=2, ADDR_STATUS=3
  - status bit positions
- Sub-module rr_arbiter (parameter N): eligible vector and pointer in, one-hot winner and next pointer out; combinational. The parent registers its outputs.

Test Plan:
- Lock: value_i=64'h0123_4567_89AB_CDEF, usr_data_i=32'h5A5A_0001, datavalid rises at cycle 0 -> ready_o=1 at cycle 2+STABLE_CNT (+/-1 for sync). Reads of addr 0/1/2 return 89AB_CDEF / 0123_4567 / 5A5A_0001.
- Unstable data: usr_data_i toggles between 1 and 2 for 5 cycles, then holds 2 -> lock on 32'h2; status[15:8]=5; status[31]=1; status[1:0]=2.
- Datavalid drop: dv low for 3 cycles mid-S_QUAL -> status shows S_SYNC path, then lock after re-qualification; no grants before ready_o.
- Contention: all 4 requesters hold req_i with addr=k -> grants 0,1,2,3,0,... one per cycle. Each rsp_valid_o[k] appears 1 cycle after gnt_o[k] with the data for addr k.
- Pre-lock requests: req_i=4'b1010 asserted before lock -> first grant to requester 1 in the cycle after ready_o rises, then requester 3.
- Reset: async rst during a grant -> gnt_o, rsp_valid_o, ready_o and rsp_data_o go to 0 immediately; after release, the FSM re-locks and the pointer restarts at 0.
